enemy_grid_mover: RTL and testbench

//  Parametrised enemy motion controller for the Bomber Man playfield: moves one enemy sprite per frame
//  in fixed point. Adds collision pushback, random turns at tile alignment, freeze and kill/respawn.

---
 rtl/enemy_grid_mover_if.sv | 25 ++
 rtl/enemy_grid_mover.sv | 202 ++++++++++++++++++++
 tb/tb_enemy_grid_mover.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_grid_mover_if.sv
// rtl/enemy_grid_mover_if.sv - frame/collision inputs and sprite outputs of one enemy mover
interface enemy_grid_mover_if;
   logic               startOfFrame;
   logic [2:0]         random_num;
   logic               collision;
   logic [3:0]         HitEdgeCode;
   logic               freeze;
   logic               kill;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic [3:0]         direction;
   logic               alive;

   // Playfield side: drives frame, collision and random inputs, observes the sprite.
   modport master (
      output startOfFrame, random_num, collision, HitEdgeCode, freeze, kill,
      input  topLeftX, topLeftY, direction, alive
   );

   // Mover side.
   modport slave (
      input  startOfFrame, random_num, collision, HitEdgeCode, freeze, kill,
      output topLeftX, topLeftY, direction, alive
   );
endinterface

// File: rtl/enemy_grid_mover.sv
// rtl/enemy_grid_mover.sv - fixed-point enemy motion with pushback, tile turns, freeze and respawn
module enemy_grid_mover #(
   parameter int         INITIAL_X      = 15,
   parameter int         INITIAL_Y      = 48,
   parameter int         SPEED          = 64,
   parameter int         FP_SHIFT       = 6,
   parameter int         OBJ_W          = 32,
   parameter int         OBJ_H          = 32,
   parameter int         FRAME_LEFT     = 15,
   parameter int         FRAME_RIGHT    = 623,
   parameter int         FRAME_TOP      = 48,
   parameter int         FRAME_BOTTOM   = 464,
   parameter int         TILE           = 32,
   parameter logic [3:0] START_DIR      = 4'b0001,
   parameter int         TURN_AT_TILE   = 1,
   parameter int         RESPAWN_FRAMES = 90
) (
   input logic               clk,
   input logic               reset,
   enemy_grid_mover_if.slave bus
);
   localparam logic [3:0] DIR_TOP    = 4'b0100;
   localparam logic [3:0] DIR_RIGHT  = 4'b0010;
   localparam logic [3:0] DIR_LEFT   = 4'b1000;
   localparam logic [3:0] DIR_BOTTOM = 4'b0001;

   localparam logic signed [31:0] INIT_XF = 32'(INITIAL_X * (1 << FP_SHIFT));
   localparam logic signed [31:0] INIT_YF = 32'(INITIAL_Y * (1 << FP_SHIFT));
   localparam logic signed [31:0] X_LO    = 32'(FRAME_LEFT * (1 << FP_SHIFT));
   localparam logic signed [31:0] X_HI    = 32'((FRAME_RIGHT - OBJ_W) * (1 << FP_SHIFT));
   localparam logic signed [31:0] Y_LO    = 32'(FRAME_TOP * (1 << FP_SHIFT));
   localparam logic signed [31:0] Y_HI    = 32'((FRAME_BOTTOM - OBJ_H) * (1 << FP_SHIFT));
   localparam logic signed [31:0] SPD     = 32'(SPEED);

   typedef enum logic [2:0] {IDLE_ST, MOVE_ST, SOF_ST, POS_CHANGE_ST, LIMITS_ST, DEAD_ST} state_t;

   state_t             state_q, state_d;
   logic signed [31:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
   logic [3:0]         dir_q, dir_d, code_q, code_d;
   logic               alive_q, alive_d, hit_q, hit_d;
   logic [15:0]        dead_q, dead_d;

   logic signed [31:0] pix_x, pix_y, dx, dy;
   logic [3:0]         cand, blocked, blocked_opp;
   logic               aligned, code_onehot;

   assign pix_x = x_q >>> FP_SHIFT;
   assign pix_y = y_q >>> FP_SHIFT;

   assign bus.topLeftX  = pix_x[10:0];
   assign bus.topLeftY  = pix_y[10:0];
   assign bus.direction = dir_q;
   assign bus.alive     = alive_q;

   assign aligned = (((pix_x - 32'(FRAME_LEFT)) % 32'(TILE)) == 32'sd0) &&
                    (((pix_y - 32'(FRAME_TOP)) % 32'(TILE)) == 32'sd0);

   // A malformed edge code falls back to the heading we were travelling in.
   assign code_onehot = (code_q != 4'b0) && ((code_q & (code_q - 4'd1)) == 4'b0);
   assign blocked     = code_onehot ? code_q : dir_q;
   assign blocked_opp = {blocked[1], blocked[0], blocked[3], blocked[2]};

   // Random candidate heading and per-direction velocity.
   always_comb begin
      cand = DIR_TOP;
      dx   = 32'sd0;
      dy   = 32'sd0;
      case (bus.random_num[1:0])
         2'd0:    cand = DIR_TOP;
         2'd1:    cand = DIR_RIGHT;
         2'd2:    cand = DIR_BOTTOM;
         default: cand = DIR_LEFT;
      endcase
      case (dir_q)
         DIR_TOP:    dy = -SPD;
         DIR_BOTTOM: dy = SPD;
         DIR_LEFT:   dx = -SPD;
         DIR_RIGHT:  dx = SPD;
         default:    ;
      endcase
   end

   // Next-state and next-register logic; kill overrides everything outside DEAD_ST.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      px_d    = px_q;
      py_d    = py_q;
      dir_d   = dir_q;
      alive_d = alive_q;
      hit_d   = hit_q;
      code_d  = code_q;
      dead_d  = dead_q;
      case (state_q)
         IDLE_ST: if (bus.startOfFrame) state_d = MOVE_ST;
         MOVE_ST: begin
            if (bus.collision && !hit_q) begin
               hit_d  = 1'b1;
               code_d = bus.HitEdgeCode;
            end
            if (bus.startOfFrame) state_d = SOF_ST;
         end
         SOF_ST: begin
            if (!bus.freeze) begin
               if (hit_q) begin
                  x_d   = px_q;
                  y_d   = py_q;
                  dir_d = (cand == blocked) ? blocked_opp : cand;
               end else if (TURN_AT_TILE != 0 && aligned && bus.random_num[2]) begin
                  dir_d = cand;
               end
            end
            hit_d   = 1'b0;
            code_d  = 4'b0;
            state_d = POS_CHANGE_ST;
         end
         POS_CHANGE_ST: begin
            if (!bus.freeze) begin
               px_d = x_q;
               py_d = y_q;
               x_d  = x_q + dx;
               y_d  = y_q + dy;
            end
            state_d = LIMITS_ST;
         end
         LIMITS_ST: begin
            if (x_q < X_LO) begin
               x_d   = X_LO;
               dir_d = DIR_RIGHT;
            end else if (x_q > X_HI) begin
               x_d   = X_HI;
               dir_d = DIR_LEFT;
            end
            if (y_q < Y_LO) begin
               y_d   = Y_LO;
               dir_d = DIR_BOTTOM;
            end else if (y_q > Y_HI) begin
               y_d   = Y_HI;
               dir_d = DIR_TOP;
            end
            state_d = MOVE_ST;
         end
         DEAD_ST: begin
            if (bus.startOfFrame && RESPAWN_FRAMES != 0) begin
               if (dead_q == 16'(RESPAWN_FRAMES - 1)) begin
                  x_d     = INIT_XF;
                  y_d     = INIT_YF;
                  px_d    = INIT_XF;
                  py_d    = INIT_YF;
                  dir_d   = START_DIR;
                  alive_d = 1'b1;
                  dead_d  = 16'd0;
                  state_d = MOVE_ST;
               end else begin
                  dead_d = dead_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE_ST;
      endcase
      if (bus.kill && state_q != DEAD_ST) begin
         x_d     = x_q;
         y_d     = y_q;
         px_d    = px_q;
         py_d    = py_q;
         dir_d   = dir_q;
         alive_d = 1'b0;
         hit_d   = 1'b0;
         code_d  = 4'b0;
         dead_d  = 16'd0;
         state_d = DEAD_ST;
      end
   end

   // State and datapath registers with synchronous reset to the spawn point.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE_ST;
         x_q     <= INIT_XF;
         y_q     <= INIT_YF;
         px_q    <= INIT_XF;
         py_q    <= INIT_YF;
         dir_q   <= START_DIR;
         alive_q <= 1'b1;
         hit_q   <= 1'b0;
         code_q  <= 4'b0;
         dead_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         px_q    <= px_d;
         py_q    <= py_d;
         dir_q   <= dir_d;
         alive_q <= alive_d;
         hit_q   <= hit_d;
         code_q  <= code_d;
         dead_q  <= dead_d;
      end
   end
endmodule

// File: tb/tb_enemy_grid_mover.sv
// tb/tb_enemy_grid_mover.sv - frame-level reference model bench for enemy_grid_mover
module tb_enemy_grid_mover;
   localparam int RESP = 3;
   localparam int FPM  = 64;
   localparam int STEP = 64;
   localparam logic [3:0] D_T = 4'b0100, D_R = 4'b0010, D_L = 4'b1000, D_B = 4'b0001;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   int         m_x, m_y, m_px, m_py, m_phase, m_cnt;
   logic [3:0] m_dir, m_code;
   bit         m_alive, m_hit;

   enemy_grid_mover_if bus();

   enemy_grid_mover #(.RESPAWN_FRAMES(RESP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] cand_of(input logic [1:0] r);
      logic [3:0] tbl [4];
      tbl = '{D_T, D_R, D_B, D_L};
      return tbl[r];
   endfunction

   function automatic logic [3:0] opp_of(input logic [3:0] d);
      if (d == D_T) return D_B;
      if (d == D_B) return D_T;
      if (d == D_L) return D_R;
      return D_L;
   endfunction

   task automatic model_spawn;
      m_x = 15 * FPM;  m_y = 48 * FPM;
      m_px = m_x;      m_py = m_y;
      m_dir = D_B;     m_alive = 1;
      m_hit = 0;       m_code = 0;
      m_cnt = 0;
   endtask

   task automatic model_frame(input bit col, input logic [3:0] c1, input bit frz,
                              input logic [2:0] rnd, input bit kl);
      logic [3:0] cand, blocked;
      if (kl && m_phase != 2) begin
         m_phase = 2; m_alive = 0; m_cnt = 0; m_hit = 0;
      end
      if (m_phase == 1 && col && !m_hit) begin
         m_hit = 1; m_code = c1;
      end
      if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 2) begin
         m_cnt++;
         if (m_cnt == RESP) begin
            model_spawn();
            m_phase = 1;
         end
      end else begin
         cand = cand_of(rnd[1:0]);
         if (!frz) begin
            if (m_hit) begin
               m_x = m_px; m_y = m_py;
               blocked = ($countones(m_code) == 1) ? m_code : m_dir;
               m_dir = (cand == blocked) ? opp_of(blocked) : cand;
            end else if (((m_x / FPM - 15) % 32 == 0) && ((m_y / FPM - 48) % 32 == 0) && rnd[2]) begin
               m_dir = cand;
            end
            m_px = m_x; m_py = m_y;
            if (m_dir == D_T) m_y -= STEP;
            if (m_dir == D_B) m_y += STEP;
            if (m_dir == D_L) m_x -= STEP;
            if (m_dir == D_R) m_x += STEP;
         end
         m_hit = 0;
         if (m_x < 15 * FPM) begin m_x = 15 * FPM; m_dir = D_R; end
         else if (m_x > 591 * FPM) begin m_x = 591 * FPM; m_dir = D_L; end
         if (m_y < 48 * FPM) begin m_y = 48 * FPM; m_dir = D_B; end
         else if (m_y > 432 * FPM) begin m_y = 432 * FPM; m_dir = D_T; end
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".x"},     int'($signed(bus.topLeftX)), m_x / FPM);
      chk({tag, ".y"},     int'($signed(bus.topLeftY)), m_y / FPM);
      chk({tag, ".dir"},   int'(bus.direction), int'(m_dir));
      chk({tag, ".alive"}, int'(bus.alive), int'(m_alive));
   endtask

   task automatic do_frame(input bit col, input logic [3:0] c1, input bit col2, input logic [3:0] c2,
                           input bit frz, input logic [2:0] rnd, input bit kl);
      bus.freeze = frz;
      if (kl) begin
         bus.kill = 1; tick; bus.kill = 0;
      end
      if (col) begin
         bus.collision = 1; bus.HitEdgeCode = c1; tick;
         if (col2) begin
            bus.HitEdgeCode = c2; tick;
         end
         bus.collision = 0;
      end
      tick;
      bus.random_num = rnd; bus.startOfFrame = 1; tick;
      bus.startOfFrame = 0;
      repeat (6) tick;
      bus.random_num = 3'($urandom);
      model_frame(col, c1, frz, rnd, kl);
      chk_model("frame");
   endtask

   task automatic run_frames(input int n, input logic [2:0] rnd);
      for (int i = 0; i < n; i++) do_frame(0, 4'b0, 0, 4'b0, 0, rnd, 0);
   endtask

   task automatic do_reset;
      bus.startOfFrame = 0; bus.random_num = 0; bus.collision = 0;
      bus.HitEdgeCode = 0;  bus.freeze = 0;     bus.kill = 0;
      reset = 1; tick; tick; reset = 0;
      model_spawn();
      m_phase = 0;
      chk("rst.x", int'($signed(bus.topLeftX)), 15);
      chk("rst.y", int'($signed(bus.topLeftY)), 48);
      chk("rst.dir", int'(bus.direction), 1);
      chk("rst.alive", int'(bus.alive), 1);
   endtask

   initial begin
      int exp_y [4];
      int fx, fy;
      exp_y = '{48, 49, 50, 51};

      // basic downward walk from spawn
      do_reset();
      for (int f = 0; f < 4; f++) begin
         run_frames(1, 3'b000);
         chk("walk.y", int'($signed(bus.topLeftY)), exp_y[f]);
         chk("walk.x", int'($signed(bus.topLeftX)), 15);
      end

      // random turn at aligned tile (47,80)
      do_reset();
      run_frames(33, 3'b000);
      do_frame(0, 0, 0, 0, 0, 3'b101, 0);
      run_frames(31, 3'b000);
      chk("align.x", int'($signed(bus.topLeftX)), 47);
      do_frame(0, 0, 0, 0, 0, 3'b110, 0);
      chk("align.dir", int'(bus.direction), int'(D_B));
      chk("align.y", int'($signed(bus.topLeftY)), 81);

      // no turn at unaligned (48,80)
      do_reset();
      run_frames(33, 3'b000);
      do_frame(0, 0, 0, 0, 0, 3'b101, 0);
      run_frames(32, 3'b000);
      do_frame(0, 0, 0, 0, 0, 3'b110, 0);
      chk("unalign.dir", int'(bus.direction), int'(D_R));
      chk("unalign.x", int'($signed(bus.topLeftX)), 49);

      // collision pushback when candidate equals blocked edge
      run_frames(51, 3'b000);
      chk("push.pre", int'($signed(bus.topLeftX)), 100);
      do_frame(1, D_R, 1, D_T, 0, 3'b001, 0);
      chk("push.x", int'($signed(bus.topLeftX)), 98);
      chk("push.dir", int'(bus.direction), int'(D_L));
      run_frames(1, 3'b000);
      chk("push.next", int'($signed(bus.topLeftX)), 97);

      // right wall clamp
      do_reset();
      run_frames(1, 3'b000);
      do_frame(0, 0, 0, 0, 0, 3'b101, 0);
      run_frames(575, 3'b000);
      chk("wall.pre", int'($signed(bus.topLeftX)), 591);
      do_frame(0, 0, 0, 0, 0, 3'b000, 0);
      chk("wall.x", int'($signed(bus.topLeftX)), 591);
      chk("wall.dir", int'(bus.direction), int'(D_L));
      run_frames(1, 3'b000);
      chk("wall.next", int'($signed(bus.topLeftX)), 590);

      // kill, ignored second kill, respawn
      do_frame(0, 0, 0, 0, 0, 3'b000, 1);
      chk("dead1.alive", int'(bus.alive), 0);
      chk("dead1.x", int'($signed(bus.topLeftX)), 590);
      do_frame(1, D_T, 0, 0, 0, 3'b000, 1);
      chk("dead2.alive", int'(bus.alive), 0);
      do_frame(0, 0, 0, 0, 0, 3'b000, 0);
      chk("resp.alive", int'(bus.alive), 1);
      chk("resp.x", int'($signed(bus.topLeftX)), 15);
      chk("resp.y", int'($signed(bus.topLeftY)), 48);
      chk("resp.dir", int'(bus.direction), 1);
      run_frames(1, 3'b000);

      // freeze with collisions
      fx = int'($signed(bus.topLeftX));
      fy = int'($signed(bus.topLeftY));
      for (int f = 0; f < 5; f++) begin
         do_frame(1, 4'($urandom), 0, 0, 1, 3'($urandom), 0);
         chk("frz.x", int'($signed(bus.topLeftX)), fx);
         chk("frz.y", int'($signed(bus.topLeftY)), fy);
         chk("frz.dir", int'(bus.direction), int'(D_B));
      end
      do_frame(0, 0, 0, 0, 0, 3'b000, 0);
      chk("thaw.y", int'($signed(bus.topLeftY)), fy + 1);
      chk("thaw.dir", int'(bus.direction), int'(D_B));

      // randomized frames against the model
      for (int f = 0; f < 400; f++) begin
         do_frame($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 1) == 1, 4'($urandom),
                  $urandom_range(0, 5) == 0, 3'($urandom), $urandom_range(0, 39) == 0);
      end

      // reset in the middle of the frame pipeline
      bus.startOfFrame = 1; tick; bus.startOfFrame = 0; tick;
      reset = 1; tick; reset = 0;
      chk("midrst.x", int'($signed(bus.topLeftX)), 15);
      chk("midrst.y", int'($signed(bus.topLeftY)), 48);
      chk("midrst.dir", int'(bus.direction), 1);
      chk("midrst.alive", int'(bus.alive), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
